perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//  Parametrised pipeline performance-counter bank; successor to the fixed five-counter CACU.
//  Counts NUM_CH single-bit event strobes from the pipeline, e.g. cycles, jumps, branches,
//  taken branches and load-use stalls. Each channel has its own counter, a sticky overflow
//  flag and a snapshot shadow register. Counting freezes on halt and LOCK is asserted.
//  Counter values are read back through a registered select port that drives the display path (TYPEC/SHOW).
// PARAMETERS
//  NUM_CH    8    number of event channels (1..16)
//  CNT_W     32   counter width in bits (8..32)
//  SEL_W     4    width of rd_sel; must satisfy 2**SEL_W >= NUM_CH
//  SATURATE  0    0 = counters wrap at 2**CNT_W; 1 = counters stick at all-ones
// PORTS
//  clk_in    in   1            CPU pipeline clock; all state updates on the rising edge
//  RST       in   1            asynchronous, active-high reset
//  en        in   1            global count enable
//  clr       in   1            synchronous clear of the counters and overflow flags
//  halt      in   1            syscall-halt indication from the WB stage
//  event     in   NUM_CH       per-channel increment strobe, +1 per cycle when high
//  snap      in   1            copy all live counters into the shadow registers
//  rd_sel    in   SEL_W        selects the channel to read
//  rd_shadow in   1            0 = read the live counter; 1 = read the shadow register
//  rd_data   out  CNT_W        registered read data
//  ovf       out  NUM_CH       sticky overflow flag for each channel
//  LOCK      out  1            counting frozen after halt; also used as the pipeline freeze
// BEHAVIOUR
//  Reset (async, RST=1):
//   - Sets all counters, shadow registers, ovf, LOCK and rd_data to 0 immediately.
//  Per-edge priority: RST, then clr, then LOCK, then counting.
//   - Counting means: cnt[i] updates when en=1, LOCK=0, clr=0 and event[i]=1.
//  Wrap and saturate rules:
//   - SATURATE=0: cnt = all-ones + 1 gives 0, and ovf[i] is set.
//   - SATURATE=1: all-ones + 1 keeps cnt at all-ones, and ovf[i] is set.
//   - ovf is cleared only by clr or RST.
//  clr:
//   - Zeroes every counter and ovf on the next edge.
//   - Does not touch the shadow registers or LOCK.
//   - Is honoured even while LOCK=1.
//  halt:
//   - Events in the cycle where halt=1 are still counted.
//   - LOCK goes to 1 at that same edge and holds until RST; clr does not release it.
//   - After that edge the counters do not change except through clr.
//  snap:
//   - Shadow[i] captures the pre-edge value of cnt[i], so any increment in the same cycle is excluded.
//   - If snap and clr are high together, the shadow takes the pre-clear values.
//   - snap works while LOCK=1.
//  Read:
//   - rd_data is registered, with 1-cycle latency from rd_sel and rd_shadow.
//   - rd_data reflects the register contents before the edge that samples the select.
//   - An rd_sel value >= NUM_CH returns 0.
//  No combinational path from any input to any output.
// TESTING
//  1. RST pulse mid-count (cnt0=5) -> rd_data, ovf, LOCK = 0 with no clock edge; counting resumes from 0.
//  2. CNT_W=8, SATURATE=0, event[0] held 257 cycles -> cnt0=1, ovf[0]=1; clr -> cnt0=0, ovf[0]=0.
//  3. CNT_W=8, SATURATE=1, event[1] held 300 cycles -> cnt1=255, ovf[1]=1.
//  4. event[2] every cycle, halt at cycle 10 -> cnt2=10 (cycles 1..10), LOCK=1 from edge 10, cnt2 stays 10 for 20 more cycles.
//  5. cnt3=7 with event[3]=1 and snap=1 -> shadow3=7, live=8; rd_sel=3, rd_shadow=1 -> rd_data=7 one cycle later.
//  6. NUM_CH=8, rd_sel=9 -> rd_data=0; en=0 with all events high for 5 cycles -> all counters unchanged.

Source files
------------

// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
//
// Parametrised bank of pipeline performance counters. Each channel counts the
// cycles in which its event strobe is high. Each channel also has a sticky
// overflow flag and a snapshot shadow register. A halt from WB freezes
// counting and raises LOCK, which stays up until RST. Counter and shadow
// values are read back through a registered select port.
//
// Parameters
//   NUM_CH    number of event channels (1..16)
//   CNT_W     counter width in bits (8..32)
//   SEL_W     width of rd_sel, 2**SEL_W >= NUM_CH
//   SATURATE  0: counters wrap to zero; 1: counters stick at all-ones
//
// Ports
//   clk_in     in   1       pipeline clock, rising edge
//   RST        in   1       asynchronous active-high reset
//   en         in   1       global count enable
//   clr        in   1       synchronous clear of counters and overflow flags
//   halt       in   1       syscall-halt indication from WB
//   events     in   NUM_CH  per-channel increment strobes ("event" is a
//                           reserved word, hence the plural)
//   snap       in   1       copy live counters into the shadow registers
//   rd_sel     in   SEL_W   channel to read
//   rd_shadow  in   1       0: read live counter, 1: read shadow register
//   rd_data    out  CNT_W   registered read data (1-cycle latency)
//   ovf        out  NUM_CH  sticky overflow flags
//   LOCK       out  1       counting frozen after halt / pipeline freeze
// -----------------------------------------------------------------------------
module perf_counter_bank #(
    parameter int NUM_CH   = 8,
    parameter int CNT_W    = 32,
    parameter int SEL_W    = 4,
    parameter int SATURATE = 0
) (
    input  logic              clk_in,
    input  logic              RST,
    input  logic              en,
    input  logic              clr,
    input  logic              halt,
    input  logic [NUM_CH-1:0] events,
    input  logic              snap,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic              rd_shadow,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] ovf,
    output logic              LOCK
);

    logic [CNT_W-1:0]  cnt_r      [NUM_CH];
    logic [CNT_W-1:0]  shadow_r   [NUM_CH];
    logic [CNT_W-1:0]  cnt_next_s [NUM_CH];
    logic [NUM_CH-1:0] ovf_r;
    logic [NUM_CH-1:0] hit_max_s;
    logic              lock_r;
    logic              count_en_s;
    logic [CNT_W-1:0]  rd_next_s;
    logic [CNT_W-1:0]  rd_data_r;

    // Global gate: counting needs enable and no halt freeze.
    always_comb begin
        count_en_s = en & ~lock_r;
    end

    // Next count per channel. hit_max_s marks an increment from all-ones,
    // which is where the overflow flag gets set in both wrap and saturate modes.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_next_s[i] = cnt_r[i];
            hit_max_s[i]  = 1'b0;
            if (count_en_s && events[i]) begin
                hit_max_s[i] = (cnt_r[i] == {CNT_W{1'b1}});
                if ((SATURATE != 0) && (cnt_r[i] == {CNT_W{1'b1}})) begin
                    cnt_next_s[i] = cnt_r[i];
                end else begin
                    cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
                end
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
        end
    end

    // Read mux as a one-hot OR. An out-of-range select matches no channel and yields 0.
    always_comb begin
        rd_next_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_next_s = rd_next_s
                      | ((rd_sel == SEL_W'(i))
                         ? (rd_shadow ? shadow_r[i] : cnt_r[i])
                         : {CNT_W{1'b0}});
        end
    end

    // State update. Shadow capture and readback both use pre-edge values. clr wins
    // over counting but leaves the shadows and LOCK alone. halt still lets the
    // events of its own cycle count, because count_en_s uses the old lock_r.
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i]    <= '0;
                shadow_r[i] <= '0;
            end
            ovf_r     <= '0;
            lock_r    <= 1'b0;
            rd_data_r <= '0;
        end else begin
            if (snap) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    shadow_r[i] <= cnt_r[i];
                end
            end
            if (halt) begin
                lock_r <= 1'b1;
            end
            if (clr) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt_r[i] <= '0;
                end
                ovf_r <= '0;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt_r[i] <= cnt_next_s[i];
                end
                ovf_r <= ovf_r | hit_max_s;
            end
            rd_data_r <= rd_next_s;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        rd_data = rd_data_r;
        ovf     = ovf_r;
        LOCK    = lock_r;
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank. It runs one wrapping instance and one
// saturating instance (both CNT_W=8, NUM_CH=8) on the same stimulus.
module tb_perf_counter_bank;

    logic       clk_in;
    logic       RST;
    logic       en;
    logic       clr;
    logic       halt;
    logic [7:0] events;
    logic       snap;
    logic [3:0] rd_sel;
    logic       rd_shadow;
    logic [7:0] rd_data_w;
    logic [7:0] rd_data_s;
    logic [7:0] ovf_w;
    logic [7:0] ovf_s;
    logic       lock_w;
    logic       lock_s;

    int n_chk = 0;
    int n_err = 0;

    perf_counter_bank #(.NUM_CH(8), .CNT_W(8), .SEL_W(4), .SATURATE(0)) u_wrap (
        .clk_in(clk_in), .RST(RST), .en(en), .clr(clr), .halt(halt),
        .events(events), .snap(snap), .rd_sel(rd_sel), .rd_shadow(rd_shadow),
        .rd_data(rd_data_w), .ovf(ovf_w), .LOCK(lock_w)
    );

    perf_counter_bank #(.NUM_CH(8), .CNT_W(8), .SEL_W(4), .SATURATE(1)) u_sat (
        .clk_in(clk_in), .RST(RST), .en(en), .clr(clr), .halt(halt),
        .events(events), .snap(snap), .rd_sel(rd_sel), .rd_shadow(rd_shadow),
        .rd_data(rd_data_s), .ovf(ovf_s), .LOCK(lock_s)
    );

    // 10 ns pipeline clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    initial begin
        RST = 1'b1; en = 1'b0; clr = 1'b0; halt = 1'b0; events = 8'h00;
        snap = 1'b0; rd_sel = 4'd0; rd_shadow = 1'b0;
        tick(2);
        check("rst_rd_w", 32'(rd_data_w), 32'd0);
        check("rst_ovf_w", 32'(ovf_w), 32'd0);
        check("rst_lock_w", 32'(lock_w), 32'd0);
        check("rst_lock_s", 32'(lock_s), 32'd0);
        RST = 1'b0;

        // 1: count to 5, then reset asynchronously mid-cycle.
        en = 1'b1; events = 8'h01; rd_sel = 4'd0;
        tick(5);
        check("t1_pre_rd", 32'(rd_data_w), 32'd4);
        RST = 1'b1;
        #1;
        check("t1_async_rd_w", 32'(rd_data_w), 32'd0);
        check("t1_async_rd_s", 32'(rd_data_s), 32'd0);
        check("t1_async_ovf", 32'(ovf_w), 32'd0);
        check("t1_async_lock", 32'(lock_w), 32'd0);
        RST = 1'b0;
        tick(3);
        events = 8'h00;
        tick(1);
        check("t1_resume", 32'(rd_data_w), 32'd3);
        do_clr();

        // 2: 257 increments on channel 0.
        events = 8'h01;
        tick(257);
        events = 8'h00;
        tick(1);
        check("t2_wrap_cnt", 32'(rd_data_w), 32'd1);
        check("t2_wrap_ovf", 32'(ovf_w), 32'h01);
        check("t2_sat_cnt", 32'(rd_data_s), 32'd255);
        check("t2_sat_ovf", 32'(ovf_s), 32'h01);
        do_clr();
        check("t2_clr_ovf_w", 32'(ovf_w), 32'd0);
        check("t2_clr_ovf_s", 32'(ovf_s), 32'd0);
        tick(1);
        check("t2_clr_cnt_w", 32'(rd_data_w), 32'd0);
        check("t2_clr_cnt_s", 32'(rd_data_s), 32'd0);

        // 3: 300 increments on channel 1.
        events = 8'h02; rd_sel = 4'd1;
        tick(300);
        events = 8'h00;
        tick(1);
        check("t3_sat_cnt", 32'(rd_data_s), 32'd255);
        check("t3_sat_ovf", 32'(ovf_s), 32'h02);
        check("t3_wrap_cnt", 32'(rd_data_w), 32'd44);
        check("t3_wrap_ovf", 32'(ovf_w), 32'h02);
        do_clr();

        // 5: snap in the same cycle as an increment on channel 3.
        events = 8'h08;
        tick(7);
        snap = 1'b1;
        tick(1);
        snap = 1'b0; events = 8'h00; rd_sel = 4'd3; rd_shadow = 1'b1;
        tick(1);
        check("t5_shadow", 32'(rd_data_w), 32'd7);
        rd_shadow = 1'b0;
        tick(1);
        check("t5_live", 32'(rd_data_w), 32'd8);

        // 6: out-of-range select, then en=0 with every event high.
        rd_sel = 4'd9;
        tick(1);
        check("t6_sel_oob", 32'(rd_data_w), 32'd0);
        en = 1'b0; events = 8'hFF;
        tick(5);
        events = 8'h00; en = 1'b1; rd_sel = 4'd3;
        tick(1);
        check("t6_en0_ch3", 32'(rd_data_w), 32'd8);
        rd_sel = 4'd5;
        tick(1);
        check("t6_en0_ch5", 32'(rd_data_s), 32'd0);
        check("t6_en0_ovf", 32'(ovf_w), 32'd0);

        // snap together with clr: the shadow keeps the pre-clear value.
        snap = 1'b1; clr = 1'b1;
        tick(1);
        snap = 1'b0; clr = 1'b0; rd_sel = 4'd3; rd_shadow = 1'b1;
        tick(1);
        check("snapclr_shadow", 32'(rd_data_w), 32'd8);
        rd_shadow = 1'b0;
        tick(1);
        check("snapclr_live", 32'(rd_data_w), 32'd0);

        // 4: channel 2 every cycle, halt in cycle 10.
        events = 8'h04;
        tick(9);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        check("t4_lock_w", 32'(lock_w), 32'd1);
        check("t4_lock_s", 32'(lock_s), 32'd1);
        tick(20);
        events = 8'h00; rd_sel = 4'd2;
        tick(1);
        check("t4_frozen", 32'(rd_data_w), 32'd10);
        check("t4_frozen_s", 32'(rd_data_s), 32'd10);
        do_clr();
        tick(1);
        check("t4_clr_locked", 32'(rd_data_w), 32'd0);
        check("t4_lock_held", 32'(lock_w), 32'd1);
        RST = 1'b1;
        #1;
        check("t4_rst_lock", 32'(lock_w), 32'd0);
        RST = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
